// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the IF stage: FSM state encoding, reset PC,
// NOP encoding and a word-alignment helper.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // request outstanding / issuing
    ST_HOLD  = 2'd1,  // fetched word parked in the skid buffer, ID stalled
    ST_DRAIN = 2'd2   // waiting out a fetch whose data will be discarded
  } fetch_state_e;

  localparam logic [31:0] FU_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus.
//   imem_req   : fetch request, held with imem_addr until imem_ack
//   imem_addr  : word-aligned fetch address
//   imem_ack   : imem_rdata valid, completes the request
//   imem_rdata : instruction word
// master = fetch unit, slave = instruction memory.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register.
//   flush      : kill the held instruction (highest priority)
//   load       : capture load_instr/load_pc as a live instruction
//   stall      : hold current contents when nothing is loaded
//   otherwise the register empties to a NOP (id_valid=0, id_instr=0).
//   if_pc4     : id_pc + 4, combinational from the register.
module if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FU_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] if_pc4
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= RESET_PC;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      pc_d    = load_pc;
    end else if (!stall) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  assign id_valid = valid_q;
  assign id_instr = instr_q;
  assign id_pc    = pc_q;
  assign if_pc4   = pc_q + 32'd4;

endmodule

// File: rtl/fetch_unit.sv
// IF stage of the 5-stage MIPS pipeline: PC register, instruction-memory
// fetch FSM (FETCH/HOLD/DRAIN), redirect latch and one-entry skid buffer.
//   clk, reset  : clock, asynchronous active-high reset
//   stall       : ID cannot accept a new instruction
//   redirect    : NPC selects redirect_pc this cycle
//   imem        : instruction-memory req/ack bus (master side)
//   if_pc4      : id_pc + 4 for NPC
//   id_valid/id_instr/id_pc : IF/ID register contents
//   align_err   : sticky, a misaligned redirect_pc was accepted
// DELAY_SLOT=1 delivers the fetch in flight at a redirect; 0 discards it.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = FU_RESET_PC,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  fetch_unit_if.master imem,
  output logic [31:0]  if_pc4,
  output logic         id_valid,
  output logic [31:0]  id_instr,
  output logic [31:0]  id_pc,
  output logic         align_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         pend_vld_q, pend_vld_d;
  logic         buf_vld_q, buf_vld_d;
  logic [31:0]  buf_instr_q, buf_instr_d;
  logic [31:0]  buf_pc_q, buf_pc_d;
  logic         align_err_q, align_err_d;

  logic         req_c;
  logic         id_load;
  logic [31:0]  id_load_instr;
  logic [31:0]  id_load_pc;
  logic         id_flush;
  logic [31:0]  fetch_addr;
  logic [31:0]  redirect_tgt;
  logic [31:0]  next_pc;

  assign fetch_addr   = word_align(pc_q);
  assign redirect_tgt = word_align(redirect_pc);
  assign id_flush     = !DELAY_SLOT && redirect;
  // A redirect landing in the same cycle as the completing ack steers the
  // very next fetch, exactly as if it had been latched a cycle earlier.
  assign next_pc      = redirect   ? redirect_tgt :
                        pend_vld_q ? pend_pc_q    : pc_q + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      pend_pc_q   <= '0;
      pend_vld_q  <= 1'b0;
      buf_vld_q   <= 1'b0;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= '0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_pc_q   <= pend_pc_d;
      pend_vld_q  <= pend_vld_d;
      buf_vld_q   <= buf_vld_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      align_err_q <= align_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_pc_d     = pend_pc_q;
    pend_vld_d    = pend_vld_q;
    buf_vld_d     = buf_vld_q;
    buf_instr_d   = buf_instr_q;
    buf_pc_d      = buf_pc_q;
    align_err_d   = align_err_q | (redirect & (redirect_pc[1:0] != 2'b00));
    req_c         = 1'b0;
    id_load       = 1'b0;
    id_load_instr = buf_instr_q;
    id_load_pc    = buf_pc_q;

    if (redirect) begin
      pend_pc_d  = redirect_tgt;
      pend_vld_d = 1'b1;
    end

    case (state_q)
      ST_FETCH: begin
        req_c = 1'b1;
        if (imem.imem_ack) begin
          pend_vld_d = 1'b0;
          if (id_flush) begin
            pc_d = redirect_tgt;
          end else begin
            pc_d = next_pc;
            if (!stall || !id_valid) begin
              id_load       = 1'b1;
              id_load_instr = imem.imem_rdata;
              id_load_pc    = fetch_addr;
            end else begin
              buf_vld_d   = 1'b1;
              buf_instr_d = imem.imem_rdata;
              buf_pc_d    = fetch_addr;
              state_d     = ST_HOLD;
            end
          end
        end else if (id_flush) begin
          state_d = ST_DRAIN;
        end
      end

      ST_HOLD: begin
        if (id_flush) begin
          buf_vld_d  = 1'b0;
          pc_d       = redirect_tgt;
          pend_vld_d = 1'b0;
          state_d    = ST_FETCH;
        end else if (!stall) begin
          id_load   = buf_vld_q;
          buf_vld_d = 1'b0;
          state_d   = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        req_c = 1'b1;
        if (imem.imem_ack) begin
          pc_d       = redirect ? redirect_tgt : pend_pc_q;
          pend_vld_d = 1'b0;
          state_d    = ST_FETCH;
        end
      end

      default: state_d = ST_FETCH;
    endcase
  end

  assign imem.imem_req  = req_c & ~reset;
  assign imem.imem_addr = fetch_addr;
  assign align_err      = align_err_q;

  if_id_reg #(
    .RESET_PC (RESET_PC)
  ) u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (id_flush),
    .load       (id_load),
    .load_instr (id_load_instr),
    .load_pc    (id_load_pc),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .if_pc4     (if_pc4)
  );

endmodule
